// File: rtl/acc_mem_host_if.sv
// Bus bundle between acc_mem_host and its peers: accelerator memory port,
// load byte stream (s_*) and dump byte stream (m_*).
interface acc_mem_host_if;
  logic [15:0] addr;
  logic [31:0] dataR;
  logic [31:0] dataW;
  logic        en;
  logic        we;
  logic        start;
  logic        finish;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;

  modport slave (
    input  addr, dataW, en, we, finish, s_valid, s_data, m_ready,
    output dataR, start, s_ready, m_valid, m_data
  );

  modport master (
    output addr, dataW, en, we, finish, s_valid, s_data, m_ready,
    input  dataR, start, s_ready, m_valid, m_data
  );
endinterface

// File: rtl/acc_mem_host.sv
// Memory responder and host sequencer for the acc edge-detection accelerator:
// load image bytes, run the accelerator, dump the result region. Optional
// access/cycle statistics ports are enabled with `define ACC_MEM_STATS_EN.
module acc_mem_host #(
  parameter int IMG_WORDS = 25344,
  parameter int DEPTH     = 50688
) (
  input  logic           clk,
  input  logic           reset,
  acc_mem_host_if.slave  bus,
  input  logic           go,
  output logic           busy,
  output logic           done,
  output logic           err
`ifdef ACC_MEM_STATS_EN
  ,
  output logic [31:0]    rd_count,
  output logic [31:0]    wr_count,
  output logic [31:0]    cycles
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] C_LAST_LOAD = AW'(IMG_WORDS - 1);
  localparam logic [CW-1:0] C_RES_FIRST = CW'(IMG_WORDS);
  localparam logic [CW-1:0] C_RES_END   = CW'(2 * IMG_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP} state_t;

  logic [31:0]   r_mem [DEPTH];
  state_t        r_state;
  logic [AW-1:0] r_loadIdx;
  logic [1:0]    r_loadByte;
  logic [23:0]   r_pack;
  logic          r_sReady;
  logic          r_start;
  logic          r_done;
  logic          r_err;
  logic [31:0]   r_dataR;
  logic          r_mValid;
  logic [7:0]    r_mData;
  logic [CW-1:0] r_dumpIdx;
  logic [31:0]   r_dumpWord;
  logic [1:0]    r_dumpByte;
  logic          r_dumpPrimed;
  logic          r_dumpLast;

  logic          w_accInRange;
  logic [AW-1:0] w_accIdx;
  logic          w_loadAccept;
  logic          w_loadWr;
  logic          w_runWr;
  logic          w_memWe;
  logic [AW-1:0] w_memAddr;
  logic [31:0]   w_memData;
  logic          w_dumpAccept;

  assign w_accInRange = ({16'd0, bus.addr} < 32'(DEPTH));
  assign w_accIdx     = bus.addr[AW-1:0];
  assign w_loadAccept = (r_state == S_LOAD) && r_sReady && bus.s_valid;
  assign w_loadWr     = w_loadAccept && (r_loadByte == 2'd3);
  assign w_runWr      = (r_state == S_RUN) && bus.en && bus.we && w_accInRange;
  assign w_memWe      = reset && (w_loadWr || w_runWr);
  assign w_memAddr    = w_loadWr ? r_loadIdx : w_accIdx;
  assign w_memData    = w_loadWr ? {bus.s_data, r_pack} : bus.dataW;
  assign w_dumpAccept = r_mValid && bus.m_ready;

  assign bus.dataR   = r_dataR;
  assign bus.start   = r_start;
  assign bus.s_ready = r_sReady;
  assign bus.m_valid = r_mValid;
  assign bus.m_data  = r_mData;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err         = r_err;

  // Storage survives reset; only the load packer and accelerator write into it.
  always_ff @(posedge clk) begin
    if (w_memWe) r_mem[w_memAddr] <= w_memData;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_loadIdx    <= '0;
      r_loadByte   <= '0;
      r_pack       <= '0;
      r_sReady     <= 1'b0;
      r_start      <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_dataR      <= '0;
      r_mValid     <= 1'b0;
      r_mData      <= '0;
      r_dumpIdx    <= '0;
      r_dumpWord   <= '0;
      r_dumpByte   <= '0;
      r_dumpPrimed <= 1'b0;
      r_dumpLast   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_state    <= S_LOAD;
            r_sReady   <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_loadIdx  <= '0;
            r_loadByte <= '0;
            r_pack     <= '0;
          end
        end
        S_LOAD: begin
          if (w_loadAccept) begin
            r_loadByte <= r_loadByte + 2'd1;
            case (r_loadByte)
              2'd0:    r_pack[7:0]   <= bus.s_data;
              2'd1:    r_pack[15:8]  <= bus.s_data;
              2'd2:    r_pack[23:16] <= bus.s_data;
              default: begin
                if (r_loadIdx == C_LAST_LOAD) begin
                  r_state  <= S_RUN;
                  r_sReady <= 1'b0;
                  r_start  <= 1'b1;
                end else begin
                  r_loadIdx <= r_loadIdx + AW'(1);
                end
              end
            endcase
          end
        end
        S_RUN: begin
          if (bus.en) begin
            if (!w_accInRange) begin
              r_err <= 1'b1;
              if (!bus.we) r_dataR <= '0;
            end else if (!bus.we) begin
              r_dataR <= r_mem[w_accIdx];
            end
          end
          // r_start marks the first RUN cycle, where finish is not yet trusted.
          if (!r_start && bus.finish) begin
            r_state      <= S_DUMP;
            r_dumpIdx    <= C_RES_FIRST;
            r_dumpByte   <= '0;
            r_dumpPrimed <= 1'b0;
            r_dumpLast   <= 1'b0;
          end
        end
        S_DUMP: begin
          if (!r_dumpPrimed) begin
            r_dumpPrimed <= 1'b1;
            r_dumpWord   <= r_mem[r_dumpIdx[AW-1:0]];
            r_mData      <= r_mem[r_dumpIdx[AW-1:0]][7:0];
            r_mValid     <= 1'b1;
            r_dumpByte   <= '0;
            r_dumpIdx    <= r_dumpIdx + CW'(1);
          end else if (w_dumpAccept) begin
            case (r_dumpByte)
              2'd0: begin
                r_mData    <= r_dumpWord[15:8];
                r_dumpByte <= 2'd1;
              end
              2'd1: begin
                r_mData    <= r_dumpWord[23:16];
                r_dumpByte <= 2'd2;
              end
              2'd2: begin
                // Top byte is now latched in r_mData, so the word register is free for the next fetch.
                r_mData    <= r_dumpWord[31:24];
                r_dumpByte <= 2'd3;
                if (r_dumpIdx == C_RES_END) begin
                  r_dumpLast <= 1'b1;
                end else begin
                  r_dumpWord <= r_mem[r_dumpIdx[AW-1:0]];
                  r_dumpIdx  <= r_dumpIdx + CW'(1);
                end
              end
              default: begin
                if (r_dumpLast) begin
                  r_mValid <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_IDLE;
                end else begin
                  r_mData    <= r_dumpWord[7:0];
                  r_dumpByte <= 2'd0;
                end
              end
            endcase
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ACC_MEM_STATS_EN
  logic [31:0] r_rdCount;
  logic [31:0] r_wrCount;
  logic [31:0] r_cycles;

  assign rd_count = r_rdCount;
  assign wr_count = r_wrCount;
  assign cycles   = r_cycles;

  always_ff @(posedge clk) begin
    if (!reset || ((r_state == S_IDLE) && go)) begin
      r_rdCount <= '0;
      r_wrCount <= '0;
      r_cycles  <= '0;
    end else if (r_state == S_RUN) begin
      r_cycles <= r_cycles + 32'd1;
      if (bus.en && w_accInRange) begin
        if (bus.we) r_wrCount <= r_wrCount + 32'd1;
        else        r_rdCount <= r_rdCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_acc_mem_host.sv
// Directed bench for acc_mem_host with read/dump scoreboards; small image size
// keeps the full load/run/dump sequence short.
module tb_acc_mem_host;
  localparam int IMG   = 64;
  localparam int DEPTH = 160;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic go = 1'b0;
  logic busy, done, err;
`ifdef ACC_MEM_STATS_EN
  logic [31:0] rd_count, wr_count, cycles;
`endif

  acc_mem_host_if bus ();

  acc_mem_host #(.IMG_WORDS(IMG), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .go    (go),
    .busy  (busy),
    .done  (done),
    .err   (err)
`ifdef ACC_MEM_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count),
    .cycles   (cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int startPulses = 0;
  int expRd = 0;
  int expWr = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] readQ [$];
  logic [7:0]  dumpQ [$];

  always @(negedge clk) if (bus.start === 1'b1) startPulses++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] imgByte(input int w, input int k);
    if (w == 0) return 8'(8'h11 * (k + 1));
    return 8'(w * 13 + k * 5 + 1);
  endfunction

  function automatic logic [31:0] imgWord(input int w);
    return {imgByte(w, 3), imgByte(w, 2), imgByte(w, 1), imgByte(w, 0)};
  endfunction

  function automatic logic [31:0] resWord(input int i);
    if (i == 0) return 32'h04030201;
    return 32'hA5C30000 ^ 32'(i * 32'h00010307);
  endfunction

  // One accelerator cycle; reads push their expected data and are checked one cycle later.
  task automatic applyStimulus(input logic en, input logic we, input logic [15:0] addr,
                               input logic [31:0] data);
    bit inRange;
    int idx;
    idx = int'(addr);
    inRange = (idx < DEPTH);
    bus.en = en;
    bus.we = we;
    bus.addr = addr;
    bus.dataW = data;
    if (en && we && inRange) begin
      model[idx] = data;
      expWr++;
    end
    if (en && !we) begin
      readQ.push_back(inRange ? model[idx] : 32'h0);
      if (inRange) expRd++;
    end
    tick();
    bus.en = 1'b0;
    bus.we = 1'b0;
    if (en && !we) checkOutput($sformatf("dataR@%0d", idx), bus.dataR, readQ.pop_front());
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".dataR"},   bus.dataR,   32'h0);
    checkOutput({tag, ".start"},   bus.start,   32'h0);
    checkOutput({tag, ".s_ready"}, bus.s_ready, 32'h0);
    checkOutput({tag, ".m_valid"}, bus.m_valid, 32'h0);
    checkOutput({tag, ".m_data"},  bus.m_data,  32'h0);
    checkOutput({tag, ".busy"},    busy,        32'h0);
    checkOutput({tag, ".done"},    done,        32'h0);
    checkOutput({tag, ".err"},     err,         32'h0);
  endtask

  task automatic loadImage();
    for (int w = 0; w < IMG; w++) begin
      model[w] = imgWord(w);
      for (int k = 0; k < 4; k++) begin
        if (w == 3 && k == 0) begin
          bus.s_valid = 1'b0;
          tick();
        end
        bus.s_valid = 1'b1;
        bus.s_data = imgByte(w, k);
        if (w == IMG - 1 && k == 3) checkOutput("start.early", bus.start, 32'h0);
        tick();
      end
    end
    bus.s_valid = 1'b0;
    checkOutput("start.pulse", bus.start, 32'h1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int cyc;
    int firstValid;
    int budget;
    bit held;
    logic [7:0] heldData;
    logic [7:0] expByte;
    logic [31:0] w;

    bus.addr = '0; bus.dataW = '0; bus.en = 1'b0; bus.we = 1'b0; bus.finish = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;

    reset = 1'b0;
    repeat (3) tick();
    checkResetValues("por");
    reset = 1'b1;
    tick();
    checkOutput("idle.busy", busy, 32'h0);

    // Start a load, then abort it with a 3-cycle reset while bytes keep arriving.
    go = 1'b1; tick(); go = 1'b0;
    checkOutput("go.s_ready", bus.s_ready, 32'h1);
    checkOutput("go.busy", busy, 32'h1);
    for (int i = 0; i < 10; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = 8'(8'hA0 + i);
      tick();
    end
    reset = 1'b0;
    repeat (3) tick();
    checkResetValues("midLoad");
    reset = 1'b1;
    bus.s_valid = 1'b0;
    tick();

    go = 1'b1; tick(); go = 1'b0;
    loadImage();

    // First RUN cycle: finish must be ignored while the read is serviced.
    bus.finish = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'd0, 32'h0);
    bus.finish = 1'b0;
    checkOutput("start.fall", bus.start, 32'h0);
    applyStimulus(1'b1, 1'b0, 16'd5, 32'h0);
    applyStimulus(1'b1, 1'b0, 16'(IMG - 1), 32'h0);

    applyStimulus(1'b1, 1'b1, 16'(IMG), 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 16'(IMG), 32'h0);
    tick();
    checkOutput("dataR.holdIdle", bus.dataR, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b1, 16'(2 * IMG), 32'h0BADF00D);
    checkOutput("dataR.holdWrite", bus.dataR, 32'hDEADBEEF);

    applyStimulus(1'b1, 1'b1, 16'(DEPTH - 1), 32'hCAFEF00D);
    applyStimulus(1'b1, 1'b0, 16'(DEPTH - 1), 32'h0);
    checkOutput("err.inRange", err, 32'h0);

    for (int i = 0; i < IMG; i++) begin
      w = resWord(i);
      applyStimulus(1'b1, 1'b1, 16'(IMG + i), w);
      for (int k = 0; k < 4; k++) dumpQ.push_back(w[8*k +: 8]);
    end

    applyStimulus(1'b1, 1'b1, 16'(256 + IMG + 1), 32'hBAD0BAD0);
    checkOutput("err.oorWrite", err, 32'h1);
    applyStimulus(1'b1, 1'b0, 16'(IMG + 1), 32'h0);
    applyStimulus(1'b1, 1'b0, 16'(DEPTH), 32'h0);
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 16'hFFFF, 32'h0);
    checkOutput("err.sticky", err, 32'h1);

    go = 1'b1; tick(); go = 1'b0;
    checkOutput("goInRun.err", err, 32'h1);
    checkOutput("goInRun.busy", busy, 32'h1);
    applyStimulus(1'b1, 1'b0, 16'd0, 32'h0);
    checkOutput("start.count", 32'(startPulses), 32'd1);

`ifdef ACC_MEM_STATS_EN
    checkOutput("stats.rd", rd_count, 32'(expRd));
    checkOutput("stats.wr", wr_count, 32'(expWr));
`endif

    bus.finish = 1'b1; tick(); bus.finish = 1'b0;

    // Dump with early back-pressure 1,0,0,1, then sustained ready.
    cyc = 0; firstValid = -1; held = 1'b0; heldData = '0;
    budget = IMG * 4 * 3 + 40;
    while (dumpQ.size() > 0 && cyc < budget) begin
      bus.m_ready = (cyc < 16) ? pat[cyc % 4] : 1'b1;
      if (held) begin
        checkOutput("dump.holdValid", bus.m_valid, 32'h1);
        checkOutput("dump.holdData", bus.m_data, heldData);
      end
      if (bus.m_valid === 1'b1 && firstValid < 0) firstValid = cyc;
      held = 1'b0;
      if (bus.m_valid === 1'b1 && bus.m_ready) begin
        expByte = dumpQ.pop_front();
        checkOutput($sformatf("dump.byte%0d", IMG * 4 - dumpQ.size() - 1), bus.m_data, expByte);
        if (dumpQ.size() == 0) checkOutput("dump.doneEarly", done, 32'h0);
      end else if (bus.m_valid === 1'b1) begin
        held = 1'b1;
        heldData = bus.m_data;
      end
      tick();
      cyc++;
    end
    bus.m_ready = 1'b0;
    checkOutput("dump.remaining", 32'(dumpQ.size()), 32'h0);
    checkOutput("dump.firstValidLatency", 32'(firstValid >= 0 && firstValid <= 2), 32'h1);
    checkOutput("dump.done", done, 32'h1);
    checkOutput("dump.busyFall", busy, 32'h0);
    checkOutput("dump.validFall", bus.m_valid, 32'h0);
    tick();
    checkOutput("done.sticky", done, 32'h1);
    checkOutput("idle.noValid", bus.m_valid, 32'h0);

    go = 1'b1; tick(); go = 1'b0;
    checkOutput("rego.done", done, 32'h0);
    checkOutput("rego.err", err, 32'h0);
    checkOutput("rego.s_ready", bus.s_ready, 32'h1);
`ifdef ACC_MEM_STATS_EN
    checkOutput("stats.rdClr", rd_count, 32'h0);
    checkOutput("stats.wrClr", wr_count, 32'h0);
    checkOutput("stats.cyclesClr", cycles, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/acc_mem_host.md
# acc_mem_host

Word-addressed memory responder and host-side sequencer for the edge-detection accelerator `acc`. It does three things in turn:
- loads a 352×288 8-bit image from a byte stream into internal memory;
- pulses `start` and services the accelerator's `en`/`we`/`addr`/`dataR`/`dataW` accesses until `finish`;
- streams the result region back out as bytes.

It is the memory/host end of the accelerator's memory interface.

## Interface
- `IMG_WORDS`, default 25344: words per image; input region `[0, IMG_WORDS)`, result region `[IMG_WORDS, 2*IMG_WORDS)`.
- `DEPTH`, default 50688: memory depth in 32-bit words; must be ≥ 2*`IMG_WORDS`.
- `clk` — input, 1 — the single clock.
- `reset` — input, 1 — synchronous, active-low reset.
- `addr` — input, 16 — accelerator word address.
- `dataR` — output, 32 — read data to the accelerator.
- `dataW` — input, 32 — write data from the accelerator.
- `en` — input, 1 — accelerator access request.
- `we` — input, 1 — accelerator write (1) / read (0).
- `start` — output, 1 — one-cycle start pulse to the accelerator.
- `finish` — input, 1 — accelerator done (level).
- `go` — input, 1 — host command to begin a load/run/dump sequence.
- `s_valid`, `s_data[7:0]` — input — load byte stream.
- `s_ready` — output, 1 — load byte stream ready.
- `m_valid`, `m_data[7:0]` — output — dump byte stream.
- `m_ready` — input, 1 — dump byte stream ready.
- `busy` — output, 1 — sequence in progress.
- `done` — output, 1 — sticky; set when the dump completes.
- `err` — output, 1 — sticky out-of-range access flag.

## Operation
- **States:** IDLE, LOAD, RUN, DUMP.
- **IDLE**
  - `go`=1 → LOAD.
  - Entering LOAD clears `done`, `err`, the load counter and the byte packer.
- **LOAD**
  - `s_ready`=1.
  - Each accepted byte (`s_valid`&`s_ready`) is packed little-endian: byte k of word w goes to bits `[8k+7:8k]`.
  - The word is written to `mem[w]` on its 4th byte.
  - After word `IMG_WORDS-1` is written → RUN.
- **RUN**
  - First cycle: `start`=1 for exactly one cycle.
  - Access servicing:
    - `en`&`we` → `mem[addr]` ← `dataW` at the clock edge.
    - `en`&!`we` → `dataR` ← `mem[addr]`, registered.
    - `en`=0, or a write cycle → `dataR` holds its previous value.
  - `finish` is ignored in the `start` cycle. It is sampled from the following cycle; on `finish`=1 → DUMP.
- **DUMP**
  - Reads words `IMG_WORDS` .. 2*`IMG_WORDS`-1.
  - Each word is emitted as 4 bytes, LSB first, on `m_data`/`m_valid`.
  - Valid/ready handshake: `m_data` is stable while `m_valid`&!`m_ready`.
  - After the last byte is accepted: `done`←1 → IDLE.
- **Out-of-range address** (`addr` ≥ `DEPTH`) in RUN:
  - read returns 0, write is dropped, `err`←1 (sticky until the next `go`).
- **Ignored inputs**
  - `en` outside RUN.
  - `s_valid` outside LOAD.
  - `go` outside IDLE.
- `busy` = (state ≠ IDLE).

## Timing
- **Reset values:** `dataR`=0, `start`=0, `s_ready`=0, `m_valid`=0, `m_data`=0, `busy`=0, `done`=0, `err`=0; state=IDLE.
- **Reset behaviour:** reset is sampled only at a clock edge. It aborts any state, including mid-LOAD and mid-DUMP. Memory contents are not cleared.
- **Read latency:** `dataR` is valid exactly 1 cycle after the `en`=1, `we`=0 cycle.
- **Write timing:** takes effect at the edge ending the `en`=1, `we`=1 cycle. A read of the same address in the next cycle returns the new value.
- **Load throughput:** 1 byte/cycle; the word write happens at the edge that accepts byte 3.
- **RUN entry:** the transition LOAD→RUN occurs the cycle after the last word write; `start` is asserted in that first RUN cycle.
- **DUMP latency:** first `m_valid` no later than 2 cycles after entering DUMP. Sustained rate 1 byte/cycle with `m_ready` held high; the next word is prefetched during byte 3.
- **Back-pressure:** a stall on `m_ready` holds all DUMP state; no bytes are dropped or duplicated.

## Configuration
- **`ACC_MEM_STATS_EN` defined:**
  - Adds outputs `rd_count[31:0]` and `wr_count[31:0]`.
  - Counters clear on reset and on `go`; each increments once per in-range accelerator read/write in RUN.
  - Adds output `cycles[31:0]`, the RUN-state cycle count.
- **Undefined:** these ports and their logic are absent; all other behaviour is identical.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles mid-LOAD → all outputs at reset values, state IDLE. A subsequent `go` reloads from byte 0.
- **Load packing:** `go`, then bytes 0x11,0x22,0x33,0x44 → `mem[0]`=0x44332211. After 101376 bytes, `start`=1 for exactly one cycle.
- **Read/write latency:** in RUN, drive `en`=1/`we`=1/`addr`=25344/`dataW`=0xDEADBEEF, then `en`=1/`we`=0/`addr`=25344 → `dataR`=0xDEADBEEF one cycle later. A following idle cycle (`en`=0) keeps `dataR` unchanged.
- **Out of range:** RUN access with `addr`=0xFFFF → `dataR`=0 on read, no memory change on write, `err`=1 sticky.
- **Dump with back-pressure:** result word 25344 = 0x04030201, `m_ready` toggling 1,0,0,1 → bytes 01,02,03,04 in order with no duplication. `done`=1 after byte 101376; `busy` falls the same cycle.
- **Stats (`ACC_MEM_STATS_EN`):** 5 reads and 3 writes in RUN → `rd_count`=5, `wr_count`=3. A new `go` clears both to 0.
